vga_fb_arbiter: RTL

Shares one single-port framebuffer memory between two users: the display fetch path, which feeds pixel colour to vga_controller, and a host write port. Display fetch keeps a small first-word-fall-through pixel FIFO filled, issuing reads in raster order from frame start. Host writes get the memory slots that display fetch does not urgently need. The block sits between the framebuffer SRAM and vga_controller's redIN/greenIN/blueIN inputs.

---
 rtl/vga_fb_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port framebuffer SRAM between the display fetch path and a
// host write port. Display fetch reads the frame in raster order into a small
// first-word-fall-through pixel FIFO that feeds vga_controller. Host writes take
// the memory slots that the fetch path does not urgently need.
//
// Ports
//   clock25Mhz  in   pixel clock, all logic on the rising edge
//   resetN      in   synchronous active-low reset
//   frameStart  in   one-cycle pulse, restart fetch at address 0
//   pixReq      in   display consumes the FIFO head this cycle
//   pixData     out  FIFO head pixel {R,G,B}, 0 when empty
//   pixValid    out  FIFO non-empty
//   underflow   out  sticky, pixReq seen while the FIFO was empty
//   fetchDone   out  all FRAME_PIX reads of this frame have issued
//   hostReq     in   host write request, held until hostAck
//   hostAddr    in   host write address
//   hostData    in   host write data
//   hostAck     out  one-cycle pulse, host write issued
//   memAddr     out  registered memory address
//   memRe       out  registered read strobe
//   memWe       out  registered write strobe
//   memWdata    out  registered write data
//   memRdata    in   read data, sampled MEM_LAT edges after the edge that raised memRe
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, no reads until the first frameStart
// FETCH  | reads allowed, fetchAddr walks 0..FRAME_PIX-1
// DONE   | every pixel of the frame has been requested, no reads

module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 4,
  parameter int MEM_LAT    = 2,
  parameter int FRAME_PIX  = 307200
) (
  input  logic              clock25Mhz,
  input  logic              resetN,
  input  logic              frameStart,
  input  logic              pixReq,
  output logic [DATA_W-1:0] pixData,
  output logic              pixValid,
  output logic              underflow,
  output logic              fetchDone,
  input  logic              hostReq,
  input  logic [ADDR_W-1:0] hostAddr,
  input  logic [DATA_W-1:0] hostData,
  output logic              hostAck,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRe,
  output logic              memWe,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata
);

  // FIFO_DEPTH is a power of two >= 2 so the pointers wrap naturally.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + MEM_LAT + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [MEM_LAT-1:0] inflight_sr;
  logic [LVL_W-1:0]  level;
  logic              rd_issue, wr_issue;
  logic              push, pop;

  // Reads already issued count against the FIFO so the returning data always
  // has a free slot waiting for it.
  always_comb begin
    level = LVL_W'(fifo_count);
    for (int i = 0; i < MEM_LAT; i++) begin
      level = level + LVL_W'(inflight_sr[i]);
    end
  end

  always_ff @(posedge clock25Mhz) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_issue   = 1'b0;
    wr_issue   = 1'b0;
    if (frameStart) begin
      state_next = S_FETCH;
    end else begin
      // The hostAck term blocks a second grant while the host is still
      // dropping hostReq after the acknowledged write.
      if (state == S_FETCH && level < LVL_W'(LOW_WATER))
        rd_issue = 1'b1;
      else if (hostReq && !hostAck)
        wr_issue = 1'b1;
      else if (state == S_FETCH && level < LVL_W'(FIFO_DEPTH))
        rd_issue = 1'b1;

      if (rd_issue && fetch_addr == ADDR_W'(FRAME_PIX - 1))
        state_next = S_DONE;
    end
  end

  always_ff @(posedge clock25Mhz) begin
    if (!resetN) begin
      fetch_addr <= '0;
      memRe      <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memWdata   <= '0;
      hostAck    <= 1'b0;
    end else begin
      memRe   <= rd_issue;
      memWe   <= wr_issue;
      hostAck <= wr_issue;
      if (frameStart) begin
        fetch_addr <= '0;
      end else if (rd_issue) begin
        memAddr    <= fetch_addr;
        fetch_addr <= fetch_addr + ADDR_W'(1);
      end else if (wr_issue) begin
        memAddr  <= hostAddr;
        memWdata <= hostData;
      end
    end
  end

  // One bit per outstanding read; the bit leaving the top marks the edge at
  // which memRdata belongs to that read.
  always_ff @(posedge clock25Mhz) begin
    if (!resetN || frameStart) begin
      inflight_sr <= '0;
    end else begin
      inflight_sr[0] <= rd_issue;
      for (int i = 1; i < MEM_LAT; i++) begin
        inflight_sr[i] <= inflight_sr[i-1];
      end
    end
  end

  // frameStart discards both the pop and any data returning on the same edge.
  assign push = inflight_sr[MEM_LAT-1] && !frameStart;
  assign pop  = pixReq && (fifo_count != '0) && !frameStart;

  always_ff @(posedge clock25Mhz) begin
    if (!resetN || frameStart) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock25Mhz) begin
    if (push) fifo_mem[wr_ptr] <= memRdata;
  end

  always_ff @(posedge clock25Mhz) begin
    if (!resetN || frameStart)
      underflow <= 1'b0;
    else if (pixReq && fifo_count == '0)
      underflow <= 1'b1;
  end

  assign pixValid  = (fifo_count != '0);
  assign pixData   = pixValid ? fifo_mem[rd_ptr] : '0;
  assign fetchDone = (state == S_DONE);

endmodule
